spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised full-duplex SPI master; the next generation of the team's 8-bit SPI master.
- Generalised in word width, SCLK divide ratio and slave-select count.
- Supports all four CPOL/CPHA modes and MSB- or LSB-first ordering, with a start/busy/done handshake.
- Fully synchronous to one system clock (no derived-clock logic); sits between a register/CPU front end and the SPI pins.

Parameters:
- DATA_W, 8: bits per transfer, >= 2.
- CLK_DIV, 16: clk cycles per SCLK half-period, >= 1.
- NUM_SS, 1: number of slave-select lines, >= 1.
- SS_W, max(1,$clog2(NUM_SS)): width of ss_sel (derived).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a transfer; sampled only in IDLE.
- cpol  in  1  SCLK idle level; latched on start.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on start.
- lsb_first  in  1  bit order; latched on start.
- ss_sel  in  SS_W  target slave index; latched on start.
- tx_data  in  DATA_W  word to send; latched on start.
- miso  in  1  serial in (already synchronised externally).
- sclk  out  1  SPI clock.
- mosi  out  1  serial out; never tristated.
- ss_n  out  NUM_SS  active-low slave selects, one-hot-low when active.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse when the transfer completes.
- rx_data  out  DATA_W  last received word, held until the next done.
- state_out  out  2  current FSM state, for monitoring.

Behaviour:
Reset values: sclk=0, mosi=0, ss_n=all 1, busy=0, done=0, rx_data=0, state=IDLE; divider and bit counters cleared.

Reset mid-transfer: all outputs return to reset values on the next clk edge and the transfer is abandoned.

FSM states: IDLE(0), SETUP(1), TRANSFER(2), DONE(3).
- IDLE:
  - sclk = configured CPOL (0 after reset); mosi = 0.
  - start=1 with ss_sel < NUM_SS: latch config and tx_data, go to SETUP.
  - start=1 with ss_sel >= NUM_SS: ignored; stays IDLE, no pulse.
- SETUP:
  - Lasts exactly CLK_DIV cycles.
  - ss_n[ss_sel]=0 and sclk=cpol on entry.
  - cpha=0: first data bit is driven on mosi on entry.
  - Then go to TRANSFER.
- TRANSFER:
  - Divider counts 0..CLK_DIV-1; sclk toggles at terminal count.
  - Exactly 2*DATA_W toggles; odd-numbered toggles are leading edges, even-numbered are trailing edges.
  - cpha=0: sample miso on leading edges; drive the next bit on trailing edges, except after the last trailing edge.
  - cpha=1: drive a bit on each leading edge; sample on trailing edges.
  - miso is captured into the shift register at the same clk edge that toggles sclk.
  - Go to DONE after the 2*DATA_W-th toggle. sclk is then back at cpol.
- DONE:
  - Lasts CLK_DIV cycles (ss hold time); ss_n stays asserted; mosi = 0.
  - On exit: ss_n = all 1, rx_data updated, done=1 for one cycle, busy=0, state = IDLE.
  - done pulses in the first IDLE cycle.

Bit order:
- lsb_first=0: tx_data[DATA_W-1] is sent first, and the first received bit lands in rx_data[DATA_W-1].
- lsb_first=1: mirrored.

Latency:
- start sampled at cycle T; done asserted at T+1+CLK_DIV*(2*DATA_W+2).
- Example: DATA_W=8, CLK_DIV=2 gives T+37.

Boundary conditions:
- start while busy: ignored, with no queueing.
- start in the same cycle done is high: accepted, because the FSM is already in IDLE, giving back-to-back transfers.
- Changes to cpol, cpha, lsb_first, tx_data or ss_sel during busy: no effect.
- CLK_DIV=1: sclk toggles every clk cycle; every rule above still holds.

Decomposition:
- Package spi_pkg holds:
  - the state encoding constants IDLE/SETUP/TRANSFER/DONE (2 bits);
  - mode constants MODE0..MODE3 as {cpol,cpha}.
- One sub-module, spi_sclk_gen, contains:
  - the half-period divider and toggle counter;
  - sclk output;
  - lead_strobe/trail_strobe one-cycle pulses;
  - last_edge flag.
  - Inputs: enable, cpol, load.
- Shift registers and the FSM stay in spi_master_param.

Test Plan:
1. Mode 0 (cpol=0, cpha=0), DATA_W=8, CLK_DIV=2, miso tied to mosi, tx_data=0xA5 -> rx_data=0xA5, done pulse exactly 37 cycles after start, 16 sclk toggles, ss_n[0] low throughout busy.
2. Mode 3 with a behavioural slave returning 0x3C, master sends 0xC3 -> slave sees 0xC3, rx_data=0x3C, sclk idles high before and after.
3. lsb_first=1, mode 1, NUM_SS=4, ss_sel=2, tx_data=0x01 -> first mosi bit is 1; only ss_n[2] goes low; the others stay 1.
4. Pulse start again mid-transfer with tx_data=0xFF -> ignored; the original word completes with one done pulse only.
5. Assert reset halfway through TRANSFER -> next cycle sclk=0, ss_n=all 1, busy=0, state_out=0, rx_data=0; a fresh transfer afterwards completes correctly.
6. start with ss_sel=5, NUM_SS=4 -> no state change and no done. Then start held high across a done -> second transfer begins the cycle after done with no idle gap.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master.
//   state_e     : FSM state encoding, also exported on state_out.
//   MODE0..MODE3: SPI mode constants packed as {cpol, cpha}.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period divider plus edge counter.
//   clk, reset   : system clock, synchronous active-high reset
//   enable       : count and toggle (high only while transferring)
//   cpol         : idle level, loaded into sclk on load
//   load         : transfer accepted; clears counters, parks sclk at cpol
//   sclk         : SPI clock
//   lead_strobe  : this clk edge makes a leading (odd-numbered) sclk toggle
//   trail_strobe : this clk edge makes a trailing (even-numbered) sclk toggle
//   last_edge    : this clk edge makes the final (2*DATA_W-th) toggle
// Strobes are combinational so the master can act on the very edge that
// toggles sclk.
module spi_sclk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic cpol,
  input  logic load,
  output logic sclk,
  output logic lead_strobe,
  output logic trail_strobe,
  output logic last_edge
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  logic [DIV_W-1:0]  div_q;
  logic [EDGE_W-1:0] edge_q;
  logic              sclk_q;
  logic              tick;

  assign tick         = enable && (div_q == DIV_W'(CLK_DIV - 1));
  // edge_q counts toggles already made; even count -> next toggle is odd (leading)
  assign lead_strobe  = tick && !edge_q[0];
  assign trail_strobe = tick &&  edge_q[0];
  assign last_edge    = tick && (edge_q == EDGE_W'(2 * DATA_W - 1));
  assign sclk         = sclk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else if (load) begin
      div_q  <= '0;
      edge_q <= '0;
      sclk_q <= cpol;
    end else if (tick) begin
      div_q  <= '0;
      edge_q <= last_edge ? '0 : edge_q + 1'b1;
      sclk_q <= ~sclk_q;
    end else if (enable) begin
      div_q  <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master (all four modes, MSB/LSB first).
//   clk, reset          : system clock, synchronous active-high reset
//   start               : transfer request, honoured only in IDLE
//   cpol/cpha/lsb_first : mode and bit order, latched on start
//   ss_sel, tx_data     : target slave and word, latched on start
//   miso                : serial in (already synchronised)
//   sclk, mosi, ss_n    : SPI pins (ss_n active low, one-hot-low)
//   busy, done          : handshake; done is a one-cycle pulse in IDLE
//   rx_data             : last received word, held until next done
//   state_out           : FSM state for monitoring
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 16,
  parameter int NUM_SS  = 1,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [1:0]        state_out
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e            state_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_q;
  logic [NUM_SS-1:0] ss_n_q;
  logic [DIV_W-1:0]  tmr_q;
  logic              mosi_q, busy_q, done_q, cpha_q, lsb_q;

  logic              sel_ok, accept, drive, sample;
  logic [NUM_SS-1:0] ss_dec;
  logic [DATA_W-1:0] tx_ord, rx_ord;
  logic              lead_strobe, trail_strobe, last_edge;

  // Slave decode by loop so an out-of-range index simply matches nothing.
  // Words are handled MSB-first internally; lsb_first is a bit reversal
  // on the way in and on the way out.
  always_comb begin
    sel_ok = 1'b0;
    ss_dec = '1;
    tx_ord = '0;
    rx_ord = '0;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SS_W'(i)) begin
        sel_ok    = 1'b1;
        ss_dec[i] = 1'b0;
      end
    end
    for (int i = 0; i < DATA_W; i++) begin
      tx_ord[i] = lsb_first ? tx_data[DATA_W-1-i] : tx_data[i];
      rx_ord[i] = lsb_q     ? rx_sh_q[DATA_W-1-i] : rx_sh_q[i];
    end
  end

  assign accept = (state_q == IDLE) && start && sel_ok;
  // cpha=0 drives the first bit at SETUP entry, so the final trailing
  // edge has nothing left to drive.
  assign drive  = cpha_q ? lead_strobe  : (trail_strobe && !last_edge);
  assign sample = cpha_q ? trail_strobe : lead_strobe;

  spi_sclk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk          (clk),
    .reset        (reset),
    .enable       (state_q == TRANSFER),
    .cpol         (cpol),
    .load         (accept),
    .sclk         (sclk),
    .lead_strobe  (lead_strobe),
    .trail_strobe (trail_strobe),
    .last_edge    (last_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      ss_n_q  <= '1;
      tmr_q   <= '0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            ss_n_q  <= ss_dec;
            cpha_q  <= cpha;
            lsb_q   <= lsb_first;
            tmr_q   <= '0;
            rx_sh_q <= '0;
            if (cpha) begin
              mosi_q  <= 1'b0;
              tx_sh_q <= tx_ord;
            end else begin
              mosi_q  <= tx_ord[DATA_W-1];
              tx_sh_q <= {tx_ord[DATA_W-2:0], 1'b0};
            end
          end
        end
        SETUP: begin
          if (tmr_q == DIV_W'(CLK_DIV - 1)) begin
            tmr_q   <= '0;
            state_q <= TRANSFER;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        TRANSFER: begin
          if (sample) rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
          if (drive) begin
            mosi_q  <= tx_sh_q[DATA_W-1];
            tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
          end
          if (last_edge) begin
            state_q <= DONE;
            mosi_q  <= 1'b0;
          end
        end
        DONE: begin
          // ss hold time: keep the slave selected for one more half-period
          if (tmr_q == DIV_W'(CLK_DIV - 1)) begin
            tmr_q   <= '0;
            state_q <= IDLE;
            ss_n_q  <= '1;
            rx_q    <= rx_ord;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mosi      = mosi_q;
  assign ss_n      = ss_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_data   = rx_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_spi_master_param.sv
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW = 8, CD = 2, NS = 4, SW = 2;
  localparam int FDW = 4, FCD = 1, FNS = 3, FSW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // main instance: DATA_W=8, CLK_DIV=2, NUM_SS=4
  logic          start = 0, cpol = 0, cpha = 0, lsb_first = 0;
  logic [SW-1:0] ss_sel = '0;
  logic [DW-1:0] tx_data = '0;
  logic          miso, sclk, mosi, busy, done;
  logic [NS-1:0] ss_n;
  logic [DW-1:0] rx_data;
  logic [1:0]    state_out;

  // fast instance: DATA_W=4, CLK_DIV=1, NUM_SS=3 (ss_sel=3 is out of range)
  logic           f_start = 0, f_cpol = 0, f_cpha = 0, f_lsb = 0;
  logic [FSW-1:0] f_ss_sel = '0;
  logic [FDW-1:0] f_tx = '0;
  logic           f_sclk, f_mosi, f_busy, f_done;
  logic [FNS-1:0] f_ss_n;
  logic [FDW-1:0] f_rx;
  logic [1:0]     f_state;

  logic loop_en = 1'b1;
  logic slv_miso = 1'b0;
  assign miso = loop_en ? mosi : slv_miso;

  spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_SS(NS)) dut (
    .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .ss_sel(ss_sel), .tx_data(tx_data), .miso(miso),
    .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .busy(busy), .done(done),
    .rx_data(rx_data), .state_out(state_out));

  spi_master_param #(.DATA_W(FDW), .CLK_DIV(FCD), .NUM_SS(FNS)) u_fast (
    .clk(clk), .reset(reset), .start(f_start), .cpol(f_cpol), .cpha(f_cpha),
    .lsb_first(f_lsb), .ss_sel(f_ss_sel), .tx_data(f_tx), .miso(f_mosi),
    .sclk(f_sclk), .mosi(f_mosi), .ss_n(f_ss_n), .busy(f_busy), .done(f_done),
    .rx_data(f_rx), .state_out(f_state));

  int total = 0, bad = 0;

  // monitors and a behavioural cpha=1 slave (MSB-first), all sampled on negedge
  int          tog_cnt = 0, done_cnt = 0, f_done_cnt = 0, ss_bad = 0;
  logic [NS-1:0] exp_ssn = '1;
  logic        prev_sclk = 0, prev_mosi = 0, prev_sel = 0;
  logic        slv_cpol = 1'b1;
  int          slv_idx = 0;
  logic [7:0]  slv_word = '0, sl_tx = '0, sl_rx = '0;
  logic        sl_first = 0;
  int          sl_cnt = 0;

  always @(negedge clk) begin
    prev_sclk <= sclk;
    prev_mosi <= mosi;
    prev_sel  <= !ss_n[slv_idx];
    if (sclk !== prev_sclk) tog_cnt <= tog_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (f_done) f_done_cnt <= f_done_cnt + 1;
    if (busy && ss_n !== exp_ssn) ss_bad <= ss_bad + 1;
    if (!ss_n[slv_idx] && !prev_sel) begin
      sl_tx  <= slv_word;
      sl_rx  <= '0;
      sl_cnt <= 0;
    end else if (!ss_n[slv_idx] && sclk !== prev_sclk) begin
      if (sclk != slv_cpol) begin
        slv_miso <= sl_tx[7];
        sl_tx    <= {sl_tx[6:0], 1'b0};
      end else begin
        sl_rx <= {sl_rx[6:0], prev_mosi};
        if (sl_cnt == 0) sl_first <= prev_mosi;
        sl_cnt <= sl_cnt + 1;
      end
    end
  end

  // present a request for one cycle on the main instance; returns at the
  // first negedge after the accepting posedge
  task automatic go(input logic [1:0] mode, input logic l, input logic [SW-1:0] sel,
                    input logic [DW-1:0] d);
    {cpol, cpha} = mode; lsb_first = l; ss_sel = sel; tx_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk got %b want 0", sclk); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got %b want 0", mosi); end
    total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL rst_ssn got %b want 1111", ss_n); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx got %h want 00", rx_data); end
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL rst_state got %0d want 0", state_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // mode 0 loopback: exact latency, 16 toggles, ss_n[0] held through busy
  task automatic test_mode0_loop;
    int t0, s0;
    loop_en = 1'b1; exp_ssn = 4'b1110;
    go(MODE0, 1'b0, 2'd0, 8'hA5);
    t0 = tog_cnt; s0 = ss_bad;
    total++; if (state_out !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL m0_setup state=%0d busy=%b want 1/1", state_out, busy); end
    repeat (35) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL m0_early_done got %b want 0 at T+36", done); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL m0_latency done=%b want 1 at T+37", done); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL m0_rx got %h want a5", rx_data); end
    total++; if (busy !== 1'b0 || state_out !== 2'd0) begin bad++; $display("FAIL m0_end busy=%b state=%0d want 0/0", busy, state_out); end
    total++; if (tog_cnt - t0 != 16) begin bad++; $display("FAIL m0_toggles got %0d want 16", tog_cnt - t0); end
    total++; if (ss_bad != s0) begin bad++; $display("FAIL m0_ss got %0d bad cycles want 0", ss_bad - s0); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL m0_pulse done=%b want 0 one cycle later", done); end
  endtask

  // mode 3 against the slave model
  task automatic test_mode3_slave;
    bit ok;
    loop_en = 1'b0; slv_cpol = 1'b1; slv_idx = 0; slv_word = 8'h3C; exp_ssn = 4'b1110;
    repeat (2) @(negedge clk);
    go(MODE3, 1'b0, 2'd0, 8'hC3);
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_setup got %b want 1", sclk); end
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL m3_timeout done=%b want 1", done); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL m3_rx got %h want 3c", rx_data); end
    total++; if (sl_rx !== 8'hC3) begin bad++; $display("FAIL m3_slave_rx got %h want c3", sl_rx); end
    repeat (3) @(negedge clk);
    total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_idle got %b want 1", sclk); end
  endtask

  // mode 1, LSB first, slave 2 of 4
  task automatic test_lsb_ss;
    bit ok;
    int s0;
    loop_en = 1'b0; slv_cpol = 1'b0; slv_idx = 2; slv_word = 8'h0F; exp_ssn = 4'b1011;
    repeat (2) @(negedge clk);
    s0 = ss_bad;
    go(MODE1, 1'b1, 2'd2, 8'h01);
    total++; if (ss_n !== 4'b1011) begin bad++; $display("FAIL lsb_ssn got %b want 1011", ss_n); end
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL lsb_timeout done=%b want 1", done); end
    total++; if (sl_first !== 1'b1) begin bad++; $display("FAIL lsb_first_bit got %b want 1", sl_first); end
    total++; if (sl_rx !== 8'h80) begin bad++; $display("FAIL lsb_slave_rx got %h want 80", sl_rx); end
    total++; if (rx_data !== 8'hF0) begin bad++; $display("FAIL lsb_rx got %h want f0", rx_data); end
    total++; if (ss_bad != s0) begin bad++; $display("FAIL lsb_ss got %0d bad cycles want 0", ss_bad - s0); end
    total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL lsb_ss_release got %b want 1111", ss_n); end
  endtask

  // start and config changes mid-transfer are ignored
  task automatic test_start_busy;
    bit ok;
    int d0, s0;
    loop_en = 1'b1; slv_idx = 0; exp_ssn = 4'b1110;
    repeat (2) @(negedge clk);
    d0 = done_cnt; s0 = ss_bad;
    go(MODE0, 1'b0, 2'd0, 8'h5A);
    repeat (10) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF; cpol = 1'b1; lsb_first = 1'b1; ss_sel = 2'd1;
    @(negedge clk);
    start = 1'b0;
    total++; if (state_out !== 2'd2) begin bad++; $display("FAIL busy_state got %0d want 2", state_out); end
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout done=%b want 1", done); end
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL busy_rx got %h want 5a", rx_data); end
    repeat (40) @(negedge clk);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_done_count got %0d want 1", done_cnt - d0); end
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL busy_idle got %0d want 0", state_out); end
    total++; if (ss_bad != s0) begin bad++; $display("FAIL busy_ss got %0d bad cycles want 0", ss_bad - s0); end
  endtask

  // synchronous reset halfway through TRANSFER, then a clean transfer
  task automatic test_reset_mid;
    bit ok;
    loop_en = 1'b1; exp_ssn = 4'b1110;
    go(MODE0, 1'b0, 2'd0, 8'h3E);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (sclk !== 1'b0 || mosi !== 1'b0) begin bad++; $display("FAIL rmid_pins sclk=%b mosi=%b want 0/0", sclk, mosi); end
    total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL rmid_ssn got %b want 1111", ss_n); end
    total++; if (busy !== 1'b0 || state_out !== 2'd0) begin bad++; $display("FAIL rmid_fsm busy=%b state=%0d want 0/0", busy, state_out); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_rx got %h want 00", rx_data); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    go(MODE0, 1'b0, 2'd0, 8'h96);
    wait_done(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout done=%b want 1", done); end
    total++; if (rx_data !== 8'h96) begin bad++; $display("FAIL rmid_rx_after got %h want 96", rx_data); end
  endtask

  // out-of-range select, then start held across done (back-to-back)
  task automatic test_bad_sel_b2b;
    int d0;
    bit ok;
    d0 = f_done_cnt;
    f_cpol = 0; f_cpha = 0; f_lsb = 0; f_ss_sel = 2'd3; f_tx = 4'hA; f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    total++; if (f_state !== 2'd0 || f_busy !== 1'b0) begin bad++; $display("FAIL badsel_state state=%0d busy=%b want 0/0", f_state, f_busy); end
    total++; if (f_ss_n !== 3'b111) begin bad++; $display("FAIL badsel_ssn got %b want 111", f_ss_n); end
    repeat (5) @(negedge clk);
    total++; if (f_done_cnt != d0) begin bad++; $display("FAIL badsel_done got %0d pulses want 0", f_done_cnt - d0); end
    f_ss_sel = 2'd1; f_start = 1'b1;
    @(negedge clk);
    total++; if (f_state !== 2'd1 || f_ss_n !== 3'b101) begin bad++; $display("FAIL b2b_first state=%0d ssn=%b want 1/101", f_state, f_ss_n); end
    repeat (9) @(negedge clk);
    total++; if (f_done !== 1'b0) begin bad++; $display("FAIL b2b_early_done got %b want 0 at T+10", f_done); end
    @(negedge clk);
    total++; if (f_done !== 1'b1 || f_rx !== 4'hA) begin bad++; $display("FAIL b2b_done1 done=%b rx=%h want 1/a", f_done, f_rx); end
    f_tx = 4'h5;
    @(negedge clk);
    total++; if (f_state !== 2'd1 || f_busy !== 1'b1) begin bad++; $display("FAIL b2b_gap state=%0d busy=%b want 1/1", f_state, f_busy); end
    f_start = 1'b0; f_tx = 4'hF;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f_done) begin ok = 1'b1; break; end
    end
    total++; if (!ok || f_rx !== 4'h5) begin bad++; $display("FAIL b2b_done2 ok=%b rx=%h want 1/5", ok, f_rx); end
  endtask

  // CLK_DIV=1, mode 3, LSB-first loopback: latency T+11
  task automatic test_clkdiv1;
    f_cpol = 1; f_cpha = 1; f_lsb = 1; f_ss_sel = 2'd0; f_tx = 4'h6; f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    total++; if (f_ss_n !== 3'b110 || f_sclk !== 1'b1) begin bad++; $display("FAIL cd1_setup ssn=%b sclk=%b want 110/1", f_ss_n, f_sclk); end
    repeat (9) @(negedge clk);
    total++; if (f_done !== 1'b0) begin bad++; $display("FAIL cd1_early_done got %b want 0", f_done); end
    @(negedge clk);
    total++; if (f_done !== 1'b1) begin bad++; $display("FAIL cd1_latency done=%b want 1 at T+11", f_done); end
    total++; if (f_rx !== 4'h6) begin bad++; $display("FAIL cd1_rx got %h want 6", f_rx); end
    total++; if (f_sclk !== 1'b1) begin bad++; $display("FAIL cd1_sclk_idle got %b want 1", f_sclk); end
  endtask

  initial begin
    test_reset;
    test_mode0_loop;
    test_mode3_slave;
    test_lsb_ss;
    test_start_busy;
    test_reset_mid;
    test_bad_sel_b2b;
    test_clkdiv1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
